// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO architectural registers plus a multi-cycle multiply/divide
// engine for the EX stage.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an op; MTHI/MTLO write in one cycle
// MUL   | product settling for MUL_LAT cycles, commits {hi,lo} on the last
// DIV   | restoring divide, one quotient bit per cycle for WIDTH cycles
// DONE  | results committed, done_o high, start_i ignored
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i, op_i   valid EX-stage op and its encoding
//   a_i, b_i        rs / rt operands
//   flushE          squash the EX-stage instruction (aborts MUL/DIV)
//   stall_o         combinational pipeline hold
//   done_o          registered, high for the DONE cycle
//   hi_o, lo_o      HI / LO registers
module hilo_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flushE,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  hi, lo;
  logic              done_q;

  // opa: multiplicand, or original dividend (needed for divide-by-zero)
  // opb: multiplier, or divisor magnitude
  // quo: dividend magnitude shifting out as quotient bits shift in
  logic [WIDTH-1:0]  opa, opb, quo, rem;
  logic              mul_sgn, neg_q, neg_r;

  logic              is_mul, is_div, sdiv;
  logic [WIDTH-1:0]  a_abs, b_abs;

  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;

  logic [WIDTH:0]    rem_sh, diff;
  logic              q_bit;
  logic [WIDTH-1:0]  rem_n, quo_n, q_fix, r_fix;

  assign is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign sdiv   = (op_i == OP_DIV);

  assign a_abs = (sdiv && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_abs = (sdiv && b_i[WIDTH-1]) ? -b_i : b_i;

  assign mul_a_ext = {{WIDTH{mul_sgn & opa[WIDTH-1]}}, opa};
  assign mul_b_ext = {{WIDTH{mul_sgn & opb[WIDTH-1]}}, opb};
  assign product   = mul_a_ext * mul_b_ext;

  // One restoring step; rem < divisor always, so WIDTH+1 bits hold the shift.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, opb};
  assign q_bit  = ~diff[WIDTH];
  assign rem_n  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_n  = {quo[WIDTH-2:0], q_bit};
  assign q_fix  = neg_q ? -quo_n : quo_n;
  assign r_fix  = neg_r ? -rem_n : rem_n;

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flushE) begin
          if (is_mul) begin
            state_d = S_MUL;
            stall_o = 1'b1;
          end else if (is_div) begin
            state_d = S_DIV;
            stall_o = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (flushE) begin
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt == MUL_LAST) state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (flushE) begin
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt == DIV_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      done_q  <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      quo     <= '0;
      rem     <= '0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          cnt <= '0;
          if (start_i && !flushE) begin
            case (op_i)
              OP_MTHI: hi <= a_i;
              OP_MTLO: lo <= a_i;
              OP_MULT, OP_MULTU: begin
                opa     <= a_i;
                opb     <= b_i;
                mul_sgn <= (op_i == OP_MULT);
              end
              OP_DIV, OP_DIVU: begin
                opa   <= a_i;
                opb   <= b_abs;
                quo   <= a_abs;
                rem   <= '0;
                neg_q <= sdiv & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                neg_r <= sdiv & a_i[WIDTH-1];
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          cnt <= cnt + CW'(1);
          if (!flushE && cnt == MUL_LAST) {hi, lo} <= product;
        end
        S_DIV: begin
          cnt <= cnt + CW'(1);
          if (!flushE) begin
            quo <= quo_n;
            rem <= rem_n;
            if (cnt == DIV_LAST) begin
              if (opb == '0) begin
                lo <= '1;
                hi <= opa;
              end else begin
                lo <= q_fix;
                hi <= r_fix;
              end
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign done_o = done_q;
  assign hi_o   = hi;
  assign lo_o   = lo;

endmodule

// File: tb/tb_hilo_mdu.sv
module tb_hilo_mdu;

  localparam int W  = 32;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [2:0]    op_i = 3'd0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          flushE = 1'b0;
  logic          stall_o, done_o;
  logic [W-1:0]  hi_o, lo_o;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  hilo_mdu #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flushE(flushE),
    .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          busy_left = 0;   // cycles of MUL/DIV work still to go
  bit          in_done   = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;

  task automatic calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin sp = sa * sb; {r_hi, r_lo} = sp; end
      3'd2: begin up = {32'b0, a} * {32'b0, b}; {r_hi, r_lo} = up; end
      3'd3: begin
        if (b == 0) begin r_lo = '1; r_hi = a; end
        else begin sq = sa / sb; sr = sa % sb; r_lo = sq[31:0]; r_hi = sr[31:0]; end
      end
      default: begin
        if (b == 0) begin r_lo = '1; r_hi = a; end
        else begin r_lo = a / b; r_hi = a % b; end
      end
    endcase
  endtask

  task automatic model_step();
    if (rst) begin
      busy_left = 0; in_done = 0; m_hi = '0; m_lo = '0;
    end else if (in_done) begin
      in_done = 0;
    end else if (busy_left > 0) begin
      if (flushE) busy_left = 0;
      else begin
        busy_left--;
        if (busy_left == 0) begin m_hi = r_hi; m_lo = r_lo; in_done = 1; end
      end
    end else if (start_i && !flushE) begin
      case (op_i)
        3'd5: m_hi = a_i;
        3'd6: m_lo = a_i;
        3'd1, 3'd2: begin calc(op_i, a_i, b_i); busy_left = ML; end
        3'd3, 3'd4: begin calc(op_i, a_i, b_i); busy_left = W; end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      bit idle, exp_stall;
      idle = (busy_left == 0) && !in_done;
      exp_stall = !rst && ((busy_left > 0 && !flushE) ||
                  (idle && start_i && !flushE && op_i >= 3'd1 && op_i <= 3'd4));
      chk("stall", 64'(stall_o), 64'(exp_stall));
      chk("done",  64'(done_o),  64'(in_done));
      chk("hi",    64'(hi_o),    64'(m_hi));
      chk("lo",    64'(lo_o),    64'(m_lo));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_mt(input logic [2:0] op, input logic [W-1:0] a);
    start_i = 1'b1; op_i = op; a_i = a; b_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 3'd0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int stalls);
    bit got;
    got = 0;
    stalls = 0;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (done_o) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) chk("done_timeout", 64'(0), 64'(1));
    #2 start_i = 1'b0; op_i = 3'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    check_en = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_hi", 64'(hi_o), 64'(0));
    chk("rst_lo", 64'(lo_o), 64'(0));
    chk("rst_stall", 64'(stall_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_mt(3'd5, 32'h12345678);
    do_mt(3'd6, 32'hCAFEBABE);
    chk("mthi", 64'(hi_o), 64'h12345678);
    chk("mtlo", 64'(lo_o), 64'hCAFEBABE);

    do_op(3'd1, 32'hFFFFFFFE, 32'd3, st);
    chk("mult_stalls", 64'(st), 64'd3);
    chk("mult_hi", 64'(hi_o), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo_o), 64'hFFFFFFFA);

    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, st);
    chk("multu_hi", 64'(hi_o), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo_o), 64'h00000001);

    do_op(3'd3, 32'hFFFFFFF9, 32'd2, st);
    chk("div_stalls", 64'(st), 64'd33);
    chk("div_lo", 64'(lo_o), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi_o), 64'hFFFFFFFF);

    do_op(3'd4, 32'd7, 32'd0, st);
    chk("divz_stalls", 64'(st), 64'd33);
    chk("divz_lo", 64'(lo_o), 64'hFFFFFFFF);
    chk("divz_hi", 64'(hi_o), 64'd7);

    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, st);
    chk("divmn_lo", 64'(lo_o), 64'h80000000);
    chk("divmn_hi", 64'(hi_o), 64'd0);

    // flush on the 5th DIV cycle
    do_mt(3'd5, 32'h11);
    do_mt(3'd6, 32'h22);
    start_i = 1'b1; op_i = 3'd4; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 flushE = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    flushE = 1'b0; start_i = 1'b0; op_i = 3'd0;
    @(negedge clk);
    chk("flush_hi", 64'(hi_o), 64'h11);
    chk("flush_lo", 64'(lo_o), 64'h22);
    chk("flush_done", 64'(done_o), 64'd0);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a MUL
    start_i = 1'b1; op_i = 3'd1; a_i = 32'd9; b_i = 32'd9;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("amid_hi", 64'(hi_o), 64'd0);
    chk("amid_lo", 64'(lo_o), 64'd0);
    chk("amid_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0; op_i = 3'd0;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    chk("amid_idle_hi", 64'(hi_o), 64'd0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      int r;
      start_i = ($urandom_range(0, 3) != 0);
      op_i = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      a_i = (r == 0) ? 32'h80000000 : (r == 1) ? 32'hFFFFFFFF :
            (r == 2) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      r = $urandom_range(0, 7);
      b_i = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFFFFFF :
            (r == 2) ? 32'($urandom_range(1, 20)) :
            (r == 3) ? -32'($urandom_range(1, 20)) : 32'($urandom);
      flushE = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    start_i = 1'b0; flushE = 1'b0; op_i = 3'd0;
    repeat (40) @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
